// File: rtl/tbec_encoder_stream.sv
// Streaming TBEC encoder: 16-bit data -> 32-bit codeword behind a DEPTH-entry buffer.
// Define TBEC_ERR_INJECT_EN to add the err_mask port (XORed into stored codewords).
module tbec_encoder_stream #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_word,
    output logic [CNT_W-1:0] words_encoded
`ifdef TBEC_ERR_INJECT_EN
    ,
    input  logic [31:0]      err_mask
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]      mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] words_q, words_d;

    logic push, pop;
    logic [31:0] enc_w, store_w;

    logic a1, a2, a3, a4, b1, b2, b3, b4;
    logic c1, c2, c3, c4, d1, d2, d3, d4;

    always_comb begin
        {a1, a2, a3, a4} = {in_data[15], in_data[11], in_data[7], in_data[3]};
        {b1, b2, b3, b4} = {in_data[14], in_data[10], in_data[6], in_data[2]};
        {c1, c2, c3, c4} = {in_data[13], in_data[9], in_data[5], in_data[1]};
        {d1, d2, d3, d4} = {in_data[12], in_data[8], in_data[4], in_data[0]};
        enc_w = {
            in_data,
            a1 ^ b2 ^ c1 ^ d2,
            a4 ^ b3 ^ c4 ^ d3,
            a2 ^ b1 ^ c2 ^ d1,
            a3 ^ b4 ^ c3 ^ d4,
            a1 ^ a2 ^ b1 ^ b2,
            c3 ^ c4 ^ d3 ^ d4,
            c1 ^ c2 ^ d1 ^ d2,
            a3 ^ a4 ^ b3 ^ b4,
            a1 ^ a3, a2 ^ a4,
            b1 ^ b3, b2 ^ b4,
            c1 ^ c3, c2 ^ c4,
            d1 ^ d3, d2 ^ d4
        };
    end

`ifdef TBEC_ERR_INJECT_EN
    assign store_w = enc_w ^ err_mask;
`else
    assign store_w = enc_w;
`endif

    assign in_ready      = (cnt_q < FULL) && !rst;
    assign out_valid     = (cnt_q != '0);
    assign out_word      = out_valid ? mem_q[rd_q] : 32'h0;
    assign words_encoded = words_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        words_d = words_q;
        if (push) wr_d = wr_q + 1'b1;
        if (pop) begin
            rd_d    = rd_q + 1'b1;
            words_d = words_q + 1'b1;
        end
        if (push && !pop) cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            words_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            words_q <= words_d;
        end
    end

    // Payload storage needs no reset; occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= store_w;
    end

endmodule
